// File: rtl/gnr_attractor_ctrl.sv
// Purpose : sweeps a range of initial states through a shared GRN node array, running
//           Floyd cycle detection per state; s0 = tortoise (odd starts), s1 = hare (every start).
// Latency : per run 1 (LOAD) + 2 per step (RUN/CHECK) + REPORT handshake; a sweep ends with a 1-cycle done.
// Backpr. : result held on res_* with res_valid until res_ready; the sweep stalls meanwhile.
//
// Ports: clk/rst (async active-low); cfg_start/cfg_init_first/cfg_init_count/cfg_max_steps
//        sweep configuration; busy/done status; reset_nos/start_s0/start_s1/init_vec drive
//        the nodes; s0_vec/s1_vec are node outputs; res_valid/res_ready/res_init/res_steps/
//        res_timeout form the result port.
module gnr_attractor_ctrl #(
    parameter int N_NODES = 4,
    parameter int STEP_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_start,
    input  logic [N_NODES-1:0] cfg_init_first,
    input  logic [N_NODES:0]   cfg_init_count,
    input  logic [STEP_W-1:0]  cfg_max_steps,
    output logic               busy,
    output logic               done,
    output logic               reset_nos,
    output logic               start_s0,
    output logic               start_s1,
    output logic [N_NODES-1:0] init_vec,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N_NODES-1:0] res_init,
    output logic [STEP_W-1:0]  res_steps,
    output logic               res_timeout
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_CHECK  = 3'd3,
        S_REPORT = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [N_NODES-1:0] r_cur_init;
    logic [N_NODES:0]   r_remaining;
    logic [STEP_W-1:0]  r_max;
    logic [STEP_W-1:0]  r_step_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_reset_nos;
    logic               r_start_s0;
    logic               r_start_s1;
    logic               r_res_valid;
    logic [N_NODES-1:0] r_res_init;
    logic [STEP_W-1:0]  r_res_steps;
    logic               r_res_timeout;

    logic               w_even;
    logic               w_meet;
    logic               w_limit;
    logic               w_hs;

    // Copies only line up as f^m / f^2m after an even number of starts;
    // at odd counts (step 1 in particular) they can agree spuriously.
    assign w_even  = ~r_step_cnt[0] && (r_step_cnt >= STEP_W'(2));
    assign w_meet  = w_even && (s0_vec == s1_vec);
    // >= so that a forced max of 0 still stops at the first check (step 1).
    assign w_limit = (r_step_cnt >= r_max);
    assign w_hs    = r_res_valid && res_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (cfg_start) w_next = (cfg_init_count == '0) ? S_FIN : S_LOAD;
            S_LOAD:   w_next = S_RUN;
            S_RUN:    w_next = S_CHECK;
            S_CHECK:  w_next = (w_meet || w_limit) ? S_REPORT : S_RUN;
            S_REPORT: if (w_hs) w_next = (r_remaining == (N_NODES+1)'(1)) ? S_FIN : S_LOAD;
            S_FIN:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_cur_init    <= '0;
            r_remaining   <= '0;
            r_max         <= '0;
            r_step_cnt    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_reset_nos   <= 1'b0;
            r_start_s0    <= 1'b0;
            r_start_s1    <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_init    <= '0;
            r_res_steps   <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            r_state     <= w_next;
            // Control strobes are decoded from the next state so they are
            // registered yet aligned with the state they belong to.
            r_reset_nos <= (w_next == S_LOAD);
            r_start_s1  <= (w_next == S_RUN);
            // Counter is unchanged between entering RUN and the start it issues,
            // so an even count now means this start is odd-numbered.
            r_start_s0  <= (w_next == S_RUN) && ~r_step_cnt[0];
            r_done      <= (w_next == S_FIN);
            r_res_valid <= (w_next == S_REPORT);

            if (r_state == S_IDLE && cfg_start) begin
                r_cur_init  <= cfg_init_first;
                r_remaining <= cfg_init_count;
                r_max       <= {cfg_max_steps[STEP_W-1:1], 1'b0};
                r_busy      <= 1'b1;
            end
            if (r_state == S_FIN) begin
                r_busy <= 1'b0;
            end

            if (w_next == S_LOAD) begin
                r_step_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_step_cnt <= r_step_cnt + STEP_W'(1);
            end

            if (r_state == S_CHECK && w_next == S_REPORT) begin
                r_res_init    <= r_cur_init;
                r_res_steps   <= r_step_cnt;
                r_res_timeout <= ~w_meet;
            end

            if (r_state == S_REPORT && w_hs && r_remaining != (N_NODES+1)'(1)) begin
                r_cur_init  <= r_cur_init + N_NODES'(1);
                r_remaining <= r_remaining - (N_NODES+1)'(1);
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign reset_nos   = r_reset_nos;
    assign start_s0    = r_start_s0;
    assign start_s1    = r_start_s1;
    assign init_vec    = r_cur_init;
    assign res_valid   = r_res_valid;
    assign res_init    = r_res_init;
    assign res_steps   = r_res_steps;
    assign res_timeout = r_res_timeout;

endmodule
